ram_dp_128kx8: RTL and testbench

- Simple dual-port, dual-clock RAM of 131072 x 8 bits. It serves as the frame buffer between the 6 MHz CGA-rate video writer and the 25 MHz VGA-rate scan reader.
- The write port runs on clk6m. The read port runs on rclk.
- Writes are unregistered-address, synchronous. Reads are registered with one-cycle latency.

---
 rtl/video_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 19 +
 rtl/ram_dp_128kx8.sv | 49 ++++
 tb/tb_ram_dp_128kx8.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants and types for the CGA-to-VGA frame-buffer path.
// The frame buffer and the scan converter both import this package.
package video_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  // One frame-buffer byte holds one pixel as packed 3:2:3 RGB.
  typedef struct packed {
    logic [2:0] red;
    logic [1:0] green;
    logic [2:0] blue;
  } pixel_t;

  function automatic pixel_t make_pixel(input logic [2:0] red,
                                        input logic [1:0] green,
                                        input logic [2:0] blue);
    pixel_t p;
    p.red   = red;
    p.green = green;
    p.blue  = blue;
    return p;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal crossing into clk's domain.
// Both flops power up low so the output starts deasserted.
module sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta = 1'b0;
  logic sync = 1'b0;

  always_ff @(posedge clk) begin
    meta <= d;
    sync <= meta;
  end

  assign q = sync;

endmodule

// File: rtl/ram_dp_128kx8.sv
// Simple dual-port, dual-clock 128K x 8 frame buffer: written at the 6 MHz
// CGA rate on clk6m, read with one-cycle registered latency on the VGA rclk.
module ram_dp_128kx8
  import video_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W,
  parameter int DEPTH_P  = DEPTH
) (
  input  logic                clk6m,
  input  logic                reset,
  input  logic                rclk,
  input  logic [ADDR_W_P-1:0] ai,
  input  logic [DATA_W_P-1:0] i,
  input  logic                w,
  input  logic [ADDR_W_P-1:0] ao,
  input  logic                r,
  output logic [DATA_W_P-1:0] o
);

  // Power-up contents are zero; reset deliberately leaves the array alone.
  logic [DATA_W_P-1:0] mem [DEPTH_P] = '{default: '0};
  logic [DATA_W_P-1:0] rd_data = '0;
  logic                rst_r;

  sync_2ff u_rst_sync (
    .clk (rclk),
    .d   (reset),
    .q   (rst_r)
  );

  always_ff @(posedge clk6m) begin
    if (w && !reset) begin
      mem[ai] <= i;
    end
  end

  // Registered read only, so the array maps onto block RAM.
  always_ff @(posedge rclk) begin
    if (rst_r) begin
      rd_data <= '0;
    end else if (r) begin
      rd_data <= mem[ao];
    end
  end

  assign o = rd_data;

endmodule

// File: tb/tb_ram_dp_128kx8.sv
// Self-checking bench for ram_dp_128kx8: directed cases plus random traffic
// compared against a plain array model of the frame buffer.
`timescale 1ns/1ps
module tb_ram_dp_128kx8;

  logic        clk6m = 1'b0;
  logic        rclk  = 1'b0;
  logic        reset = 1'b0;
  logic [16:0] ai    = '0;
  logic [7:0]  i     = '0;
  logic        w     = 1'b0;
  logic [16:0] ao    = '0;
  logic        r     = 1'b0;
  logic [7:0]  o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] ref_mem [131072];

  always #83 clk6m = ~clk6m;
  always #20 rclk  = ~rclk;

  ram_dp_128kx8 dut (
    .clk6m (clk6m),
    .reset (reset),
    .rclk  (rclk),
    .ai    (ai),
    .i     (i),
    .w     (w),
    .ao    (ao),
    .r     (r),
    .o     (o)
  );

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
    end
  endtask

  // One clk6m write; the model only changes when the write is allowed.
  task automatic applyStimulus(input logic [16:0] addr, input logic [7:0] data);
    @(negedge clk6m);
    ai = addr;
    i  = data;
    w  = 1'b1;
    @(posedge clk6m);
    #1;
    w = 1'b0;
    if (!reset) ref_mem[addr] = data;
    repeat (3) @(posedge rclk);
  endtask

  task automatic readCheck(input string tag, input logic [16:0] addr);
    @(negedge rclk);
    ao = addr;
    r  = 1'b1;
    @(posedge rclk);
    #1;
    r = 1'b0;
    checkOutput(tag, o, ref_mem[addr]);
  endtask

  initial begin
    logic [16:0] pool [8];
    logic [16:0] addr;

    for (int k = 0; k < 131072; k++) ref_mem[k] = 8'h00;

    // Power-up reset
    reset = 1'b1;
    repeat (3) @(posedge clk6m);
    #1;
    checkOutput("reset_o", o, 8'h00);
    @(negedge clk6m);
    reset = 1'b0;
    repeat (5) @(posedge rclk);

    // Basic write/read
    applyStimulus(17'h00000, 8'hA5);
    readCheck("basic_0", 17'h00000);

    // Address extremes, no aliasing
    applyStimulus(17'h0FFFF, 8'h11);
    applyStimulus(17'h10000, 8'h22);
    applyStimulus(17'h1FFFF, 8'h33);
    readCheck("addr_0FFFF", 17'h0FFFF);
    readCheck("addr_10000", 17'h10000);
    readCheck("addr_1FFFF", 17'h1FFFF);
    readCheck("addr_00001", 17'h00001);
    readCheck("addr_00000", 17'h00000);

    // Write-enable gating
    @(negedge clk6m);
    ai = 17'h00100;
    i  = 8'hFF;
    w  = 1'b0;
    repeat (10) @(posedge clk6m);
    repeat (3) @(posedge rclk);
    readCheck("w_gate", 17'h00100);

    // Read-enable hold
    readCheck("hold_pre", 17'h00000);
    @(negedge rclk);
    ao = 17'h0FFFF;
    r  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge rclk);
      #1;
      checkOutput($sformatf("hold_%0d", k), o, 8'hA5);
    end
    @(negedge rclk);
    r = 1'b1;
    @(posedge rclk);
    #1;
    checkOutput("hold_release", o, 8'h11);
    r = 1'b0;

    // Reset blocks writes, zeroes o, suppresses reads, keeps contents
    @(negedge clk6m);
    reset = 1'b1;
    w     = 1'b1;
    ai    = 17'h00200;
    i     = 8'h5A;
    @(negedge rclk);
    ao = 17'h0FFFF;
    r  = 1'b1;
    @(posedge clk6m);
    repeat (3) @(posedge rclk);
    #1;
    checkOutput("reset_o_3edges", o, 8'h00);
    repeat (3) @(posedge clk6m);
    #1;
    checkOutput("reset_o_held", o, 8'h00);
    @(negedge clk6m);
    reset = 1'b0;
    w     = 1'b0;
    r     = 1'b0;
    @(posedge clk6m);
    repeat (5) @(posedge rclk);
    readCheck("reset_no_write", 17'h00200);
    readCheck("reset_retain", 17'h0FFFF);

    // Random traffic, clustered so reads often hit written addresses
    for (int k = 0; k < 8; k++) pool[k] = 17'($urandom);
    for (int k = 0; k < 200; k++) begin
      addr = ($urandom_range(0, 3) == 0) ? 17'($urandom) : pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) applyStimulus(addr, 8'($urandom));
      else readCheck($sformatf("rand_%0d", k), addr);
    end

    // Streaming write, then continuous read-back
    for (int k = 0; k < 1024; k++) begin
      @(negedge clk6m);
      ai = 17'(k);
      i  = 8'(k + 8'h40);
      w  = 1'b1;
      ref_mem[k] = 8'(k + 8'h40);
    end
    @(negedge clk6m);
    w = 1'b0;
    repeat (3) @(posedge rclk);
    for (int k = 0; k < 1024; k++) begin
      @(negedge rclk);
      ao = 17'(k);
      r  = 1'b1;
      @(posedge rclk);
      #1;
      checkOutput($sformatf("stream_%0d", k), o, ref_mem[k]);
    end
    r = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
